// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache.
//   state_e             : controller state encoding (idle, line fill, write-through)
//   INDEX_BITS_DEFAULT  : default log2 of the line count
//   TAG_BITS            : tag width derived from the default index width
package dcache_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StWrite = 2'd2
  } state_e;

  localparam int unsigned INDEX_BITS_DEFAULT = 4;
  // 32-bit byte address minus index bits minus the two byte-offset bits.
  localparam int unsigned TAG_BITS = 32 - INDEX_BITS_DEFAULT - 2;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache, one 32-bit word per line.
// Ports:
//   i_clk, i_rst      : clock and synchronous active-high reset (clears valid bits only)
//   i_idx             : line index shared by the read and write ports
//   o_valid/o_tag/o_data : combinational read of the indexed line
//   i_we, i_be, i_wdata  : byte-enabled synchronous data write
//   i_tag_we, i_tag      : tag write that also marks the line valid
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEFAULT,
  parameter int unsigned TAG_W      = 30 - INDEX_BITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [INDEX_BITS-1:0] i_idx,
  output logic                  o_valid,
  output logic [TAG_W-1:0]      o_tag,
  output logic [31:0]           o_data,
  input  logic                  i_we,
  input  logic [3:0]            i_be,
  input  logic [31:0]           i_wdata,
  input  logic                  i_tag_we,
  input  logic [TAG_W-1:0]      i_tag
);

  localparam int unsigned Lines = 1 << INDEX_BITS;

  logic [Lines-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [Lines];
  logic [31:0]      r_data [Lines];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
    end else if (i_tag_we) begin
      r_valid[i_idx] <= 1'b1;
    end
  end

  // Tag and data contents survive reset; only the valid bits are cleared.
  always_ff @(posedge i_clk) begin
    if (i_tag_we) begin
      r_tag[i_idx] <= i_tag;
    end
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_be[b]) begin
        r_data[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Ports:
//   clk_i, rst_i                : clock, synchronous active-high reset
//   ReqValid_i, MemWrite_i, ByteOp_i, Address_i, WriteData_i : CPU request
//   ReadData_o, Stall_o         : load word (address bits [1:0] ignored), pipeline hold
//   MemReq_o, MemWe_o, MemAddr_o, MemWdata_o, MemBe_o : backing-memory request
//   MemAck_i, MemRdata_i        : backing-memory completion and read word
//   HitCount_o, MissCount_o     : load hit/miss statistics
// Build option: define DCACHE_STATS_EN to build the statistics counters; otherwise
// both counter outputs are tied to zero.
module data_cache
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ReqValid_i,
  input  logic        MemWrite_i,
  input  logic        ByteOp_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        Stall_o,
  output logic        MemReq_o,
  output logic        MemWe_o,
  output logic [31:0] MemAddr_o,
  output logic [31:0] MemWdata_o,
  output logic [3:0]  MemBe_o,
  input  logic        MemAck_i,
  input  logic [31:0] MemRdata_i,
  output logic [31:0] HitCount_o,
  output logic [31:0] MissCount_o
);

  localparam int unsigned TagW = 30 - INDEX_BITS;

  state_e r_state, w_state_next;
  // Marks the idle cycle right after a write-through completes, so the store that is
  // still presented by the stalled requester is retired instead of re-issued.
  logic   r_wr_done, w_wr_done_next;

  logic [INDEX_BITS-1:0] w_idx;
  logic [TagW-1:0]       w_tag;
  logic                  w_line_valid;
  logic [TagW-1:0]       w_line_tag;
  logic [31:0]           w_line_data;
  logic                  w_hit;

  logic        w_fill;
  logic        w_wr;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_arr_we;
  logic        w_arr_tag_we;
  logic [3:0]  w_arr_be;
  logic [31:0] w_arr_wdata;

  assign w_idx = Address_i[INDEX_BITS+1:2];
  assign w_tag = Address_i[31:INDEX_BITS+2];
  assign w_hit = w_line_valid && (w_line_tag == w_tag);

  assign w_be    = ByteOp_i ? (4'b0001 << Address_i[1:0]) : 4'b1111;
  assign w_wdata = ByteOp_i ? {4{WriteData_i[7:0]}} : WriteData_i;

  // Memory-side address/data/enables are driven unconditionally; only MemReq_o qualifies them.
  assign MemAddr_o  = {Address_i[31:2], 2'b00};
  assign MemWdata_o = w_wdata;
  assign MemBe_o    = w_be;
  assign ReadData_o = w_line_data;

  always_comb begin
    w_state_next   = r_state;
    w_wr_done_next = 1'b0;
    Stall_o        = 1'b0;
    MemReq_o       = 1'b0;
    MemWe_o        = 1'b0;
    w_fill         = 1'b0;
    w_wr           = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (ReqValid_i && !r_wr_done) begin
          if (MemWrite_i) begin
            Stall_o      = 1'b1;
            w_state_next = StWrite;
          end else if (!w_hit) begin
            Stall_o      = 1'b1;
            w_state_next = StFill;
          end
        end
      end
      StFill: begin
        MemReq_o = 1'b1;
        Stall_o  = 1'b1;
        if (MemAck_i) begin
          w_fill       = 1'b1;
          w_state_next = StIdle;
        end
      end
      StWrite: begin
        MemReq_o = 1'b1;
        MemWe_o  = 1'b1;
        Stall_o  = 1'b1;
        if (MemAck_i) begin
          w_wr           = w_hit;
          w_wr_done_next = 1'b1;
          w_state_next   = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_wr_done <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_wr_done <= w_wr_done_next;
    end
  end

  // Reset in the ack cycle aborts the access, so writes are blocked while rst_i is high.
  assign w_arr_we     = (w_fill || w_wr) && !rst_i;
  assign w_arr_tag_we = w_fill && !rst_i;
  assign w_arr_be     = w_fill ? 4'b1111 : w_be;
  assign w_arr_wdata  = w_fill ? MemRdata_i : w_wdata;

  dcache_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_W     (TagW)
  ) u_array (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_idx    (w_idx),
    .o_valid  (w_line_valid),
    .o_tag    (w_line_tag),
    .o_data   (w_line_data),
    .i_we     (w_arr_we),
    .i_be     (w_arr_be),
    .i_wdata  (w_arr_wdata),
    .i_tag_we (w_arr_tag_we),
    .i_tag    (w_tag)
  );

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic        w_cnt_hit;
  logic        w_cnt_miss;

  assign w_cnt_hit  = (r_state == StIdle) && ReqValid_i && !MemWrite_i && !r_wr_done && w_hit;
  assign w_cnt_miss = (r_state == StIdle) && (w_state_next == StFill);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else begin
      if (w_cnt_hit) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_cnt_miss) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign HitCount_o  = r_hit_cnt;
  assign MissCount_o = r_miss_cnt;
`else
  assign HitCount_o  = 32'd0;
  assign MissCount_o = 32'd0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios followed by random accesses,
// checked against a word-address-level cache model and a sparse backing-memory model.
module tb_data_cache;

  logic        clk;
  logic        rst_i;
  logic        ReqValid_i;
  logic        MemWrite_i;
  logic        ByteOp_i;
  logic [31:0] Address_i;
  logic [31:0] WriteData_i;
  logic [31:0] ReadData_o;
  logic        Stall_o;
  logic        MemReq_o;
  logic        MemWe_o;
  logic [31:0] MemAddr_o;
  logic [31:0] MemWdata_o;
  logic [3:0]  MemBe_o;
  logic        MemAck_i;
  logic [31:0] MemRdata_i;
  logic [31:0] HitCount_o;
  logic [31:0] MissCount_o;

  data_cache u_dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .ReqValid_i  (ReqValid_i),
    .MemWrite_i  (MemWrite_i),
    .ByteOp_i    (ByteOp_i),
    .Address_i   (Address_i),
    .WriteData_i (WriteData_i),
    .ReadData_o  (ReadData_o),
    .Stall_o     (Stall_o),
    .MemReq_o    (MemReq_o),
    .MemWe_o     (MemWe_o),
    .MemAddr_o   (MemAddr_o),
    .MemWdata_o  (MemWdata_o),
    .MemBe_o     (MemBe_o),
    .MemAck_i    (MemAck_i),
    .MemRdata_i  (MemRdata_i),
    .HitCount_o  (HitCount_o),
    .MissCount_o (MissCount_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: each line remembers which word address it holds.
  bit          m_valid [16];
  logic [29:0] m_waddr [16];
  logic [31:0] m_data  [16];
  logic [31:0] bmem    [logic [29:0]];
  int unsigned m_hits  = 0;
  int unsigned m_miss  = 0;

  logic [31:0] last_rd;
  int          last_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bget(input logic [29:0] wa);
    if (bmem.exists(wa)) return bmem[wa];
    return {wa[15:0], ~wa[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_cnt(input int unsigned v);
`ifdef DCACHE_STATS_EN
    return v;
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endtask

  // One complete access; the memory responder acks after n wait cycles of MemReq_o.
  task automatic acc(input bit we, input bit bop, input logic [31:0] addr,
                     input logic [31:0] wd, input int n);
    int          idx;
    logic [29:0] wa;
    bit          hit;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] erd;
    int          exp_st;
    int          st;
    int          rq;
    bit          done;
    bit          acked;
    logic        o_we;
    logic [3:0]  o_be;
    logic [31:0] o_wd;
    logic [31:0] o_ad;
    logic        o_req;
    idx    = int'(addr[5:2]);
    wa     = addr[31:2];
    hit    = m_valid[idx] && (m_waddr[idx] == wa);
    ebe    = bop ? (4'b0001 << addr[1:0]) : 4'b1111;
    ewd    = bop ? {4{wd[7:0]}} : wd;
    erd    = hit ? m_data[idx] : bget(wa);
    exp_st = (!we && hit) ? 0 : n + 2;
    st = 0; rq = 0; done = 1'b0; acked = 1'b0;
    o_we = 1'b0; o_be = 4'h0; o_wd = 32'h0; o_ad = 32'h0; o_req = 1'b0;
    ReqValid_i  = 1'b1;
    MemWrite_i  = we;
    ByteOp_i    = bop;
    Address_i   = addr;
    WriteData_i = wd;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!Stall_o) begin
        done    = 1'b1;
        last_rd = ReadData_o;
        o_req   = MemReq_o;
      end else begin
        st++;
        if (MemReq_o) begin
          if (rq == n) begin
            MemAck_i   = 1'b1;
            MemRdata_i = bget(wa);
            acked = 1'b1;
            o_we  = MemWe_o;
            o_be  = MemBe_o;
            o_wd  = MemWdata_o;
            o_ad  = MemAddr_o;
          end
          rq++;
        end
        @(posedge clk);
        #1;
        MemAck_i = 1'b0;
      end
    end
    last_st = st;
    chk("complete", {31'd0, done}, 32'd1);
    if (done) begin
      @(posedge clk);
      #1;
    end
    ReqValid_i = 1'b0;
    chk("stall_cycles", st, exp_st);
    chk("memreq_at_done", {31'd0, o_req}, 32'd0);
    if (!(!we && hit)) begin
      chk("mem_acked", {31'd0, acked}, 32'd1);
      chk("mem_we", {31'd0, o_we}, {31'd0, we});
      chk("mem_addr", o_ad, {wa, 2'b00});
    end
    if (we) begin
      chk("mem_be", {28'd0, o_be}, {28'd0, ebe});
      chk("mem_wdata", o_wd, ewd);
      bmem[wa] = merge(bget(wa), ewd, ebe);
      if (hit) m_data[idx] = merge(m_data[idx], ewd, ebe);
    end else begin
      chk("read_data", last_rd, erd);
      if (!hit) begin
        m_valid[idx] = 1'b1;
        m_waddr[idx] = wa;
        m_data[idx]  = erd;
        m_miss++;
      end
      m_hits++;
    end
  endtask

  initial begin
    rst_i = 1'b1; ReqValid_i = 1'b0; MemWrite_i = 1'b0; ByteOp_i = 1'b0;
    Address_i = 32'h0; WriteData_i = 32'h0; MemAck_i = 1'b0; MemRdata_i = 32'h0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'd0, Stall_o}, 32'd0);
    chk("rst_memreq", {31'd0, MemReq_o}, 32'd0);
    chk("rst_hits", HitCount_o, 32'd0);
    chk("rst_miss", MissCount_o, 32'd0);
    @(posedge clk);
    #1;

    // Read miss with 3 wait cycles: 5 stall cycles, then the hit.
    bmem[30'h40] = 32'hDEADBEEF;
    acc(1'b0, 1'b0, 32'h100, 32'h0, 3);
    chk("miss_latency", last_st, 32'd5);
    chk("fill_data", last_rd, 32'hDEADBEEF);
    chk("hits_after_fill", HitCount_o, exp_cnt(1));
    chk("miss_after_fill", MissCount_o, exp_cnt(1));

    // Word store hit, then byte store hit.
    acc(1'b1, 1'b0, 32'h100, 32'h11223344, 1);
    acc(1'b0, 1'b0, 32'h100, 32'h0, 0);
    chk("word_store_hit", last_rd, 32'h11223344);
    chk("word_store_nostall", last_st, 32'd0);
    acc(1'b1, 1'b1, 32'h102, 32'h000000AA, 0);
    acc(1'b0, 1'b0, 32'h100, 32'h0, 0);
    chk("byte_merge", last_rd, 32'h11AA3344);

    // Store to an uncached address must not allocate.
    acc(1'b1, 1'b0, 32'h200, 32'hCAFEF00D, 2);
    acc(1'b0, 1'b0, 32'h200, 32'h0, 1);
    chk("no_allocate", last_st, 32'd3);

    // Conflict eviction on index 0.
    acc(1'b0, 1'b0, 32'h140, 32'h0, 0);
    acc(1'b0, 1'b0, 32'h100, 32'h0, 2);
    chk("evicted_reload", last_st, 32'd4);
    chk("evicted_data", last_rd, 32'h11AA3344);

    // Random traffic over four conflicting pages.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      acc($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, ra, $urandom,
          $urandom_range(0, 3));
    end
    chk("rand_hits", HitCount_o, exp_cnt(m_hits));
    chk("rand_miss", MissCount_o, exp_cnt(m_miss));

    // Reset in the middle of a fill, coinciding with an ack that must be dropped.
    ReqValid_i = 1'b1; MemWrite_i = 1'b0; ByteOp_i = 1'b0; Address_i = 32'h300;
    @(negedge clk);
    chk("abort_idle_stall", {31'd0, Stall_o}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_in_fill", {31'd0, MemReq_o}, 32'd1);
    MemAck_i = 1'b1; MemRdata_i = 32'h0BAD0BAD; rst_i = 1'b1; ReqValid_i = 1'b0;
    @(posedge clk);
    #1;
    MemAck_i = 1'b0; rst_i = 1'b0;
    @(negedge clk);
    chk("abort_memreq", {31'd0, MemReq_o}, 32'd0);
    chk("abort_stall", {31'd0, Stall_o}, 32'd0);
    chk("abort_hits", HitCount_o, 32'd0);
    chk("abort_miss", MissCount_o, 32'd0);
    @(posedge clk);
    #1;
    clear_model();
    acc(1'b0, 1'b0, 32'h300, 32'h0, 1);
    chk("post_abort_miss", last_st, 32'd3);
    acc(1'b0, 1'b0, 32'h100, 32'h0, 0);
    chk("post_reset_invalid", last_st, 32'd2);
    chk("final_hits", HitCount_o, exp_cnt(m_hits));
    chk("final_miss", MissCount_o, exp_cnt(m_miss));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
